// File: rtl/riscv_muldiv_unit.sv
// rtl/riscv_muldiv_unit.sv - multi-cycle RV32M/RV64M multiply/divide unit
//
// Sits beside the execute-stage ALU. Multiplies take MUL_LAT cycles. Divides use a
// restoring radix-2 loop that produces one quotient bit per cycle. Divide-by-zero and
// signed overflow produce their architectural results one cycle after accept.
//
// Ports:
//   iCLK, iRST            clock (rising edge), asynchronous active-low reset
//   iValid/oReady         request handshake (oReady only in IDLE)
//   iOp, iA, iB           funct3 and raw rs1/rs2 bits, latched on accept
//   iFlush                abort any in-flight op, result discarded
//   oValid/iReady         result handshake, oValid held until iReady
//   oResult, oDivByZero   result and divide-by-zero flag, qualified by oValid
//   oBusy                 unit not in IDLE
`timescale 1ns/1ps

module riscv_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iValid,
  output logic            oReady,
  input  logic [2:0]      iOp,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iFlush,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oResult,
  output logic            oDivByZero,
  output logic            oBusy
);

  localparam int CW = $clog2(XLEN + MUL_LAT + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV_SETUP,
    DIV_ITER,
    DIV_FIX,
    DONE
  } stateType;

  stateType        state;
  logic [2:0]      opReg;
  logic [XLEN-1:0] aReg;
  logic [XLEN-1:0] bReg;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] divisor;
  logic            negQuo;
  logic            negRem;

  // Operand decode (only meaningful once the op has been latched).
  logic isSignedDiv;
  logic isRem;
  logic aNeg;
  logic bNeg;
  logic divByZero;
  logic overflow;

  assign isSignedDiv = ~opReg[0];
  assign isRem       = opReg[1];
  assign aNeg        = isSignedDiv & aReg[XLEN-1];
  assign bNeg        = isSignedDiv & bReg[XLEN-1];
  assign divByZero   = (bReg == '0);
  assign overflow    = isSignedDiv & (aReg == MIN_INT) & (bReg == '1);

  // Multiplier: operands extended to 2*XLEN per op; the product is held stable for
  // MUL_LAT cycles, so it can be timed as a multicycle path.
  logic                aSigned;
  logic                bSigned;
  logic [2*XLEN-1:0]   aExt;
  logic [2*XLEN-1:0]   bExt;
  logic [2*XLEN-1:0]   product;

  assign aSigned = (opReg[1:0] != 2'b11);
  assign bSigned = ~opReg[1];
  assign aExt    = {{XLEN{aSigned & aReg[XLEN-1]}}, aReg};
  assign bExt    = {{XLEN{bSigned & bReg[XLEN-1]}}, bReg};
  assign product = aExt * bExt;

  // Restoring step: shift next dividend bit into the partial remainder and subtract.
  // The partial remainder is always below the divisor, so one extra bit suffices and
  // the top bit of the difference is the borrow.
  logic [XLEN:0]   remShift;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] quoFixed;
  logic [XLEN-1:0] remFixed;

  assign remShift = {rem, quo[XLEN-1]};
  assign diff     = remShift - {1'b0, divisor};
  assign fits     = ~diff[XLEN];
  assign quoFixed = negQuo ? -quo : quo;
  assign remFixed = negRem ? -rem : rem;

  assign oReady = (state == IDLE);
  assign oBusy  = (state != IDLE);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state      <= IDLE;
      opReg      <= '0;
      aReg       <= '0;
      bReg       <= '0;
      cnt        <= '0;
      quo        <= '0;
      rem        <= '0;
      divisor    <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      oValid     <= 1'b0;
      oResult    <= '0;
      oDivByZero <= 1'b0;
    end else if (iFlush) begin
      state  <= IDLE;
      oValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            opReg <= iOp;
            aReg  <= iA;
            bReg  <= iB;
            cnt   <= '0;
            state <= iOp[2] ? DIV_SETUP : MUL;
          end
        end
        MUL: begin
          if (cnt == MUL_LAST) begin
            oResult    <= (opReg[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
            oDivByZero <= 1'b0;
            oValid     <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV_SETUP: begin
          if (divByZero) begin
            oResult    <= isRem ? aReg : '1;
            oDivByZero <= 1'b1;
            oValid     <= 1'b1;
            state      <= DONE;
          end else if (overflow) begin
            oResult    <= isRem ? '0 : aReg;
            oDivByZero <= 1'b0;
            oValid     <= 1'b1;
            state      <= DONE;
          end else begin
            quo     <= aNeg ? -aReg : aReg;
            rem     <= '0;
            divisor <= bNeg ? -bReg : bReg;
            negQuo  <= aNeg ^ bNeg;
            negRem  <= aNeg;
            cnt     <= '0;
            state   <= DIV_ITER;
          end
        end
        DIV_ITER: begin
          quo <= {quo[XLEN-2:0], fits};
          rem <= fits ? diff[XLEN-1:0] : remShift[XLEN-1:0];
          if (cnt == DIV_LAST) begin
            state <= DIV_FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV_FIX: begin
          oResult    <= isRem ? remFixed : quoFixed;
          oDivByZero <= 1'b0;
          oValid     <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb/tb_riscv_muldiv_unit.sv - randomized self-checking bench for riscv_muldiv_unit
`timescale 1ns/1ps

module tb_riscv_muldiv_unit;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic            iCLK;
  logic            iRST;
  logic            iValid;
  logic            oReady;
  logic [2:0]      iOp;
  logic [XLEN-1:0] iA;
  logic [XLEN-1:0] iB;
  logic            iFlush;
  logic            oValid;
  logic            iReady;
  logic [XLEN-1:0] oResult;
  logic            oDivByZero;
  logic            oBusy;

  int nChecks = 0;
  int nFails  = 0;

  riscv_muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iValid(iValid),
    .oReady(oReady),
    .iOp(iOp),
    .iA(iA),
    .iB(iB),
    .iFlush(iFlush),
    .oValid(oValid),
    .iReady(iReady),
    .oResult(oResult),
    .oDivByZero(oDivByZero),
    .oBusy(oBusy)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural result computed with 64-bit arithmetic; returns {divByZero, result}.
  function automatic logic [32:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    if (op[2] && b == 32'd0)
      return op[1] ? {1'b1, a} : {1'b1, 32'hFFFF_FFFF};
    case (op)
      3'd0: begin p = sa * sb;           return {1'b0, p[31:0]};  end
      3'd1: begin p = sa * sb;           return {1'b0, p[63:32]}; end
      3'd2: begin p = sa * longint'(ub); return {1'b0, p[63:32]}; end
      3'd3: begin p = ua * ub;           return {1'b0, p[63:32]}; end
      3'd4: begin p = sa / sb;           return {1'b0, p[31:0]};  end
      3'd5: begin p = ua / ub;           return {1'b0, p[31:0]};  end
      3'd6: begin p = sa % sb;           return {1'b0, p[31:0]};  end
      default: begin p = ua % ub;        return {1'b0, p[31:0]};  end
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one request, measures latency, checks the result, optionally holds it
  // for some cycles with a competing request pending, then consumes it.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [32:0] exp;
    logic [31:0] held;
    int          lat;
    int          k;
    exp = refModel(op, a, b);
    lat = expLatency(op, a, b);
    iOp = op;
    iA = a;
    iB = b;
    iValid = 1'b1;
    @(posedge iCLK);
    #1;
    iValid = 1'b0;
    iOp = 3'($urandom);
    iA = $urandom;
    iB = $urandom;
    k = 0;
    while (!oValid && k < 200) begin
      @(posedge iCLK);
      #1;
      k++;
    end
    checkEq($sformatf("latency op%0d", op), 32'(k), 32'(lat));
    checkEq($sformatf("result op%0d a=%08h b=%08h", op, a, b), oResult, exp[31:0]);
    checkEq($sformatf("divByZero op%0d", op), 32'(oDivByZero), 32'(exp[32]));
    held = oResult;
    for (int i = 0; i < hold; i++) begin
      iValid = 1'b1;
      @(posedge iCLK);
      #1;
      checkEq("hold oValid", 32'(oValid), 32'd1);
      checkEq("hold oReady", 32'(oReady), 32'd0);
      checkEq("hold oResult", oResult, held);
    end
    iValid = 1'b0;
    iReady = 1'b1;
    @(posedge iCLK);
    #1;
    iReady = 1'b0;
    checkEq("consumed oValid", 32'(oValid), 32'd0);
    checkEq("consumed oReady", 32'(oReady), 32'd1);
  endtask

  initial begin
    int sawValid;
    iRST = 1'b0;
    iValid = 1'b0;
    iOp = '0;
    iA = '0;
    iB = '0;
    iFlush = 1'b0;
    iReady = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    checkEq("reset oValid", 32'(oValid), 32'd0);
    checkEq("reset oResult", oResult, 32'd0);
    checkEq("reset oDivByZero", 32'(oDivByZero), 32'd0);
    checkEq("reset oBusy", 32'(oBusy), 32'd0);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    checkEq("post-reset oReady", 32'(oReady), 32'd1);

    // Directed cases
    runOp(3'd0, 32'd7, -32'd3, 0);
    runOp(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    runOp(3'd2, 32'h8000_0000, 32'h8000_0000, 0);
    runOp(3'd3, 32'h8000_0000, 32'h8000_0000, 0);
    runOp(3'd4, -32'd7, 32'd2, 0);
    runOp(3'd6, -32'd7, 32'd2, 0);
    runOp(3'd5, 32'd100, 32'd7, 0);
    runOp(3'd7, 32'd100, 32'd7, 0);
    runOp(3'd4, 32'd5, 32'd0, 0);
    runOp(3'd7, 32'd5, 32'd0, 0);
    runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    runOp(3'd5, 32'd100, 32'd7, 10);

    // Flush at divide iteration 10
    iOp = 3'd4; iA = 32'd12345; iB = 32'd17; iValid = 1'b1;
    @(posedge iCLK);
    #1;
    iValid = 1'b0;
    repeat (11) @(posedge iCLK);
    #1;
    iFlush = 1'b1;
    @(posedge iCLK);
    #1;
    iFlush = 1'b0;
    checkEq("flush oBusy", 32'(oBusy), 32'd0);
    checkEq("flush oReady", 32'(oReady), 32'd1);
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge iCLK);
      #1;
      if (oValid) sawValid = 1;
    end
    checkEq("flush no result", 32'(sawValid), 32'd0);
    runOp(3'd0, 32'd6, 32'd9, 0);

    // Flush with a request in IDLE drops it
    iOp = 3'd0; iA = 32'd3; iB = 32'd3; iValid = 1'b1; iFlush = 1'b1;
    @(posedge iCLK);
    #1;
    iValid = 1'b0; iFlush = 1'b0;
    checkEq("flush drop oBusy", 32'(oBusy), 32'd0);

    // Flush wins over iReady in DONE
    iOp = 3'd3; iA = 32'hFFFF_FFFF; iB = 32'd2; iValid = 1'b1;
    @(posedge iCLK);
    #1;
    iValid = 1'b0;
    repeat (MUL_LAT) @(posedge iCLK);
    #1;
    checkEq("pre-flush oValid", 32'(oValid), 32'd1);
    iFlush = 1'b1; iReady = 1'b1;
    @(posedge iCLK);
    #1;
    iFlush = 1'b0; iReady = 1'b0;
    checkEq("flush done oValid", 32'(oValid), 32'd0);
    checkEq("flush done oReady", 32'(oReady), 32'd1);

    // Asynchronous reset mid-divide
    iOp = 3'd5; iA = 32'hDEAD_BEEF; iB = 32'd3; iValid = 1'b1;
    @(posedge iCLK);
    #1;
    iValid = 1'b0;
    repeat (5) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    #1;
    checkEq("async reset oBusy", 32'(oBusy), 32'd0);
    checkEq("async reset oValid", 32'(oValid), 32'd0);
    checkEq("async reset oResult", oResult, 32'd0);
    checkEq("async reset oDivByZero", 32'(oDivByZero), 32'd0);
    @(posedge iCLK);
    #2;
    iRST = 1'b1;
    @(posedge iCLK);
    #1;
    runOp(3'd6, 32'd100, -32'd7, 0);

    // Randomized ops against the reference model
    for (int n = 0; n < 250; n++) begin
      runOp(3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
